jk_bank_arbiter: RTL and testbench

Two-port command arbiter and sequencer for a bank of WIDTH JK flip-flops. Two requesters issue single-bit commands (hold/read, clear, set, toggle) through a valid/ready handshake. The block grants one requester at a time, round-robin on conflict, and drives one-cycle j/k pulses into the addressed flip-flop. It then samples the flip-flop's new q and returns it to the winner with a done pulse. The bank's own set/reset inputs are not driven by this block and are tied to 0 at the top level.

---
 rtl/jk_bank_arbiter_if.sv | 42 ++++
 rtl/jk_bank_arbiter.sv | 142 ++++++++++++++
 tb/tb_jk_bank_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/jk_bank_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_arbiter_if
// Description : Requester-side bundle for jk_bank_arbiter. It carries the two
//               command channels (valid/op/idx/ready) and the shared
//               completion signals (done/rdata/err/busy).
// Revision    : 1.0 - initial release
// ============================================================================
interface jk_bank_arbiter_if #(
    parameter int IDX_W = 3
);
    logic             req_valid_a;
    logic [1:0]       req_op_a;
    logic [IDX_W-1:0] req_idx_a;
    logic             req_ready_a;
    logic             req_valid_b;
    logic [1:0]       req_op_b;
    logic [IDX_W-1:0] req_idx_b;
    logic             req_ready_b;
    logic             done_a;
    logic             done_b;
    logic             rdata;
    logic             err;
    logic             busy;

    // Requester side: issues commands and observes completion.
    modport master (
        output req_valid_a, req_op_a, req_idx_a,
        output req_valid_b, req_op_b, req_idx_b,
        input  req_ready_a, req_ready_b,
        input  done_a, done_b, rdata, err, busy
    );

    // Arbiter side.
    modport slave (
        input  req_valid_a, req_op_a, req_idx_a,
        input  req_valid_b, req_op_b, req_idx_b,
        output req_ready_a, req_ready_b,
        output done_a, done_b, rdata, err, busy
    );
endinterface
`default_nettype wire

// File: rtl/jk_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_arbiter
// Description : Two-port round-robin command arbiter that pulses j/k into one
//               flip-flop of a JK bank, then samples and returns its new q.
//               Fixed sequence IDLE -> ISSUE -> SAMPLE -> DONE -> IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_bank_arbiter #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    jk_bank_arbiter_if.slave      bus,
    output logic [WIDTH-1:0]      j,
    output logic [WIDTH-1:0]      k,
    input  wire logic [WIDTH-1:0] q
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic             GRANT_A = 1'b0;
    localparam logic             GRANT_B = 1'b1;
    localparam logic [IDX_W:0]   LIMIT   = (IDX_W+1)'(WIDTH);

    state_t             state_q;
    logic               last_grant_q;
    logic               src_q;
    logic [IDX_W-1:0]   idx_q;
    logic               err_flag_q;
    logic [WIDTH-1:0]   j_q;
    logic [WIDTH-1:0]   k_q;
    logic               done_a_q;
    logic               done_b_q;
    logic               rdata_q;
    logic               err_q;
    logic               busy_q;

    logic               win_a;
    logic               win_b;
    logic               accept;
    logic [1:0]         in_op;
    logic [IDX_W-1:0]   in_idx;
    logic               in_range;
    logic [WIDTH-1:0]   onehot;
    logic               q_sel;

    // Winner selection: a lone requester wins; on conflict the one not
    // granted most recently wins.
    always_comb begin
        win_a    = bus.req_valid_a && (!bus.req_valid_b || (last_grant_q == GRANT_B));
        win_b    = bus.req_valid_b && (!bus.req_valid_a || (last_grant_q == GRANT_A));
        accept   = (state_q == S_IDLE) && (win_a || win_b);
        in_op    = win_b ? bus.req_op_b  : bus.req_op_a;
        in_idx   = win_b ? bus.req_idx_b : bus.req_idx_a;
        in_range = ({1'b0, in_idx} < LIMIT);
    end

    // Decode the incoming index to a one-hot bank select (zero if out of range)
    // and pick the latched bit of q for the read-back.
    always_comb begin
        onehot = '0;
        q_sel  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_idx == IDX_W'(i)) onehot[i] = 1'b1;
            if (idx_q  == IDX_W'(i)) q_sel     = q[i];
        end
    end

    // Command sequencer with registered bank drives and responses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= GRANT_B;
            src_q        <= GRANT_A;
            idx_q        <= '0;
            err_flag_q   <= 1'b0;
            j_q          <= '0;
            k_q          <= '0;
            done_a_q     <= 1'b0;
            done_b_q     <= 1'b0;
            rdata_q      <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        src_q        <= win_b;
                        last_grant_q <= win_b;
                        idx_q        <= in_idx;
                        err_flag_q   <= !in_range;
                        j_q          <= onehot & {WIDTH{in_op[1]}};
                        k_q          <= onehot & {WIDTH{in_op[0]}};
                        busy_q       <= 1'b1;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // The bank captures the pulse on this closing edge.
                    j_q     <= '0;
                    k_q     <= '0;
                    state_q <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    rdata_q  <= err_flag_q ? 1'b0 : q_sel;
                    err_q    <= err_flag_q;
                    done_a_q <= (src_q == GRANT_A);
                    done_b_q <= (src_q == GRANT_B);
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    rdata_q  <= 1'b0;
                    err_q    <= 1'b0;
                    done_a_q <= 1'b0;
                    done_b_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready_a = (state_q == S_IDLE) && win_a;
    assign bus.req_ready_b = (state_q == S_IDLE) && win_b;
    assign bus.done_a      = done_a_q;
    assign bus.done_b      = done_b_q;
    assign bus.rdata       = rdata_q;
    assign bus.err         = err_q;
    assign bus.busy        = busy_q;
    assign j               = j_q;
    assign k               = k_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_bank_arbiter
// Description : Directed self-checking bench for jk_bank_arbiter with a
//               behavioural JK bank. dut1 is WIDTH=8, dut2 is WIDTH=6.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_bank_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] j1, k1;
    logic [7:0] q1 = '0;
    logic [5:0] j2, k2;
    logic [5:0] q2 = '0;
    int         n_assert = 0;
    int         n_fail   = 0;

    jk_bank_arbiter_if #(.IDX_W(3)) bus1 ();
    jk_bank_arbiter_if #(.IDX_W(3)) bus2 ();

    jk_bank_arbiter #(.WIDTH(8), .IDX_W(3)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1.slave), .j(j1), .k(k1), .q(q1)
    );
    jk_bank_arbiter #(.WIDTH(6), .IDX_W(3)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2.slave), .j(j2), .k(k2), .q(q2)
    );

    always #5 clk = ~clk;

    // Behavioural JK banks (set/reset inputs tied low).
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++)
            case ({j1[i], k1[i]})
                2'b01:   q1[i] <= 1'b0;
                2'b10:   q1[i] <= 1'b1;
                2'b11:   q1[i] <= ~q1[i];
                default: q1[i] <= q1[i];
            endcase
        for (int i = 0; i < 6; i++)
            case ({j2[i], k2[i]})
                2'b01:   q2[i] <= 1'b0;
                2'b10:   q2[i] <= 1'b1;
                2'b11:   q2[i] <= ~q2[i];
                default: q2[i] <= q2[i];
            endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Invariants checked every cycle outside reset.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("done_excl", {31'd0, bus1.done_a && bus1.done_b}, 32'd0);
            chk("ready_busy", {31'd0, (bus1.req_ready_a || bus1.req_ready_b) && bus1.busy}, 32'd0);
        end
    end

    task automatic drive(input bit use2, input bit src_b, input logic v,
                         input logic [1:0] op, input logic [2:0] idx);
        if (!use2) begin
            if (!src_b) begin bus1.req_valid_a = v; bus1.req_op_a = op; bus1.req_idx_a = idx; end
            else        begin bus1.req_valid_b = v; bus1.req_op_b = op; bus1.req_idx_b = idx; end
        end else begin
            if (!src_b) begin bus2.req_valid_a = v; bus2.req_op_a = op; bus2.req_idx_a = idx; end
            else        begin bus2.req_valid_b = v; bus2.req_op_b = op; bus2.req_idx_b = idx; end
        end
    endtask

    task automatic obs(input bit use2, output logic [7:0] oj, output logic [7:0] ok,
                       output logic ra, output logic rb, output logic da, output logic db,
                       output logic rd, output logic er, output logic bz);
        if (!use2) begin
            oj = j1; ok = k1; ra = bus1.req_ready_a; rb = bus1.req_ready_b;
            da = bus1.done_a; db = bus1.done_b; rd = bus1.rdata; er = bus1.err; bz = bus1.busy;
        end else begin
            oj = {2'b00, j2}; ok = {2'b00, k2}; ra = bus2.req_ready_a; rb = bus2.req_ready_b;
            da = bus2.done_a; db = bus2.done_b; rd = bus2.rdata; er = bus2.err; bz = bus2.busy;
        end
    endtask

    // One complete command, started at a negedge with the DUT idle; ends at
    // the negedge where the DUT is idle again.
    task automatic run_cmd(input string tag, input bit use2, input bit src_b,
                           input logic [1:0] op, input logic [2:0] idx,
                           input logic [7:0] ej, input logic [7:0] ek,
                           input logic erd, input logic eer);
        logic [7:0] oj, ok;
        logic ra, rb, da, db, rd, er, bz;
        drive(use2, src_b, 1'b1, op, idx);
        #1;
        obs(use2, oj, ok, ra, rb, da, db, rd, er, bz);
        chk({tag, ".ready"}, {30'd0, ra, rb}, src_b ? 32'd1 : 32'd2);
        @(negedge clk);
        drive(use2, src_b, 1'b0, 2'b00, 3'd0);
        obs(use2, oj, ok, ra, rb, da, db, rd, er, bz);
        chk({tag, ".issue_jk"}, {16'd0, oj, ok}, {16'd0, ej, ek});
        chk({tag, ".issue_busy"}, {31'd0, bz}, 32'd1);
        @(negedge clk);
        obs(use2, oj, ok, ra, rb, da, db, rd, er, bz);
        chk({tag, ".sample_jk"}, {16'd0, oj, ok}, 32'd0);
        chk({tag, ".sample_done"}, {30'd0, da, db}, 32'd0);
        @(negedge clk);
        obs(use2, oj, ok, ra, rb, da, db, rd, er, bz);
        chk({tag, ".done"}, {30'd0, da, db}, src_b ? 32'd1 : 32'd2);
        chk({tag, ".rdata_err"}, {30'd0, rd, er}, {30'd0, erd, eer});
        @(negedge clk);
        obs(use2, oj, ok, ra, rb, da, db, rd, er, bz);
        chk({tag, ".idle"}, {28'd0, da, db, rd, bz}, 32'd0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 2'b00, 3'd0);
        drive(1'b0, 1'b1, 1'b0, 2'b00, 3'd0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 3'd0);
        drive(1'b1, 1'b1, 1'b0, 2'b00, 3'd0);

        // Reset held with random requester activity.
        for (int n = 0; n < 3; n++) begin
            drive(1'b0, 1'b0, 1'($urandom), 2'($urandom), 3'($urandom));
            drive(1'b0, 1'b1, 1'($urandom), 2'($urandom), 3'($urandom));
            @(negedge clk);
            chk("rst.jk", {16'd0, j1, k1}, 32'd0);
            chk("rst.outs", {27'd0, bus1.done_a, bus1.done_b, bus1.rdata, bus1.err, bus1.busy}, 32'd0);
            chk("rst.jk2", {20'd0, j2, k2}, 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 2'b00, 3'd0);
        drive(1'b0, 1'b1, 1'b0, 2'b00, 3'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Set then read.
        run_cmd("set3",  1'b0, 1'b0, 2'b10, 3'd3, 8'h08, 8'h00, 1'b1, 1'b0);
        chk("set3.q", {24'd0, q1}, 32'h08);
        run_cmd("hold3", 1'b0, 1'b0, 2'b00, 3'd3, 8'h00, 8'h00, 1'b1, 1'b0);
        // Toggle then clear from B.
        run_cmd("tgl7",  1'b0, 1'b1, 2'b11, 3'd7, 8'h80, 8'h80, 1'b1, 1'b0);
        chk("tgl7.q", {24'd0, q1}, 32'h88);
        run_cmd("clr7",  1'b0, 1'b1, 2'b01, 3'd7, 8'h00, 8'h80, 1'b0, 1'b0);
        chk("clr7.q", {24'd0, q1}, 32'h08);

        // Out of range on the 6-bit bank.
        run_cmd("oor6",  1'b1, 1'b0, 2'b10, 3'd6, 8'h00, 8'h00, 1'b0, 1'b1);
        chk("oor6.q", {26'd0, q2}, 32'd0);

        // Reset during ISSUE of a set command.
        drive(1'b0, 1'b0, 1'b1, 2'b10, 3'd5);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 2'b00, 3'd0);
        chk("mid.issue_j", {24'd0, j1}, 32'h20);
        #1 reset_n = 1'b0;
        #1;
        chk("mid.async_jk", {16'd0, j1, k1}, 32'd0);
        chk("mid.async_busy", {31'd0, bus1.busy}, 32'd0);
        @(negedge clk);
        chk("mid.q", {24'd0, q1}, 32'h08);
        reset_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("mid.quiet", {29'd0, bus1.done_a, bus1.done_b, bus1.busy}, 32'd0);
        end

        // Continuous conflict: A (hold idx3, q=1) and B (hold idx7, q=0).
        drive(1'b0, 1'b0, 1'b1, 2'b00, 3'd3);
        drive(1'b0, 1'b1, 1'b1, 2'b00, 3'd7);
        for (int g = 0; g < 4; g++) begin
            #1;
            chk("conf.ready", {30'd0, bus1.req_ready_a, bus1.req_ready_b}, (g % 2 == 1) ? 32'd1 : 32'd2);
            @(negedge clk);
            chk("conf.gap1", {30'd0, bus1.req_ready_a, bus1.req_ready_b}, 32'd0);
            @(negedge clk);
            chk("conf.gap2", {30'd0, bus1.req_ready_a, bus1.req_ready_b}, 32'd0);
            @(negedge clk);
            chk("conf.gap3", {30'd0, bus1.req_ready_a, bus1.req_ready_b}, 32'd0);
            chk("conf.done", {29'd0, bus1.done_a, bus1.done_b, bus1.rdata},
                (g % 2 == 1) ? 32'd2 : 32'd5);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 1'b0, 2'b00, 3'd0);
        drive(1'b0, 1'b1, 1'b0, 2'b00, 3'd0);
        repeat (5) @(negedge clk);
        chk("end.busy", {31'd0, bus1.busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
